pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 12 +
 rtl/adder_segment.sv | 27 ++
 rtl/pipelined_adder.sv | 128 ++++++++++++
 tb/tb_pipelined_adder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and segment-width derivation for the pipelined adder.
package pipelined_adder_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefStages = 4;

  // Bits handled by each pipeline stage; guards against a zero stage count.
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG-bit ripple-carry adder built from 1-bit full adders.
module adder_segment #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           carry_in,
  output logic [SEG-1:0] sum,
  output logic           carry_out
);

  logic [SEG:0] carry;

  // Ripple the carry through one full adder per bit.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = carry_in;
    for (int i = 0; i < SEG; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out = carry[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: one segment per stage, operands skewed in, sums deskewed out,
// with a valid/ready handshake that freezes the whole pipe while the output is stalled.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic             out_overflow
);

  localparam int unsigned Seg  = seg_width(WIDTH, STAGES);
  localparam int unsigned Last = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES (STAGES >= 1)");
  end

  // Stage k register: x holds finished sum bits below the stage boundary and the
  // still-unprocessed A bits above it, so the full word exits as the sum.
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] x_q     [STAGES];
  logic             ovf_q;

  logic             v_in  [STAGES];
  logic             c_in  [STAGES];
  logic [WIDTH-1:0] x_in  [STAGES];
  logic [WIDTH-1:0] y_in  [STAGES];
  logic [Seg-1:0]   s_seg [STAGES];
  logic             c_seg [STAGES];
  logic [WIDTH-1:0] x_d   [STAGES];
  logic             ovf_d;
  logic             stall;

  assign stall    = valid_q[Last] && !out_ready;
  assign in_ready = !stall;

  // Stage inputs: stage 0 from the ports, later stages from the previous register.
  always_comb begin
    v_in[0] = in_valid;
    c_in[0] = in_carry;
    x_in[0] = in_a;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = valid_q[k-1];
      c_in[k] = carry_q[k-1];
      x_in[k] = x_q[k-1];
    end
  end

  // B operand skew chain; only needed when there is more than one stage.
  assign y_in[0] = in_b;
  if (STAGES > 1) begin : g_skew
    logic [WIDTH-1:0] y_q [STAGES-1];

    // Carry B forward alongside its beat, frozen on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < STAGES - 1; k++) y_q[k] <= '0;
      end else if (!stall) begin
        for (int k = 0; k < STAGES - 1; k++) y_q[k] <= y_in[k];
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_tap
      assign y_in[k] = y_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(
      .SEG(Seg)
    ) u_adder_segment (
      .a        (x_in[k][k*Seg +: Seg]),
      .b        (y_in[k][k*Seg +: Seg]),
      .carry_in (c_in[k]),
      .sum      (s_seg[k]),
      .carry_out(c_seg[k])
    );
  end

  // Replace the segment just added with its sum bits.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      x_d[k]                = x_in[k];
      x_d[k][k*Seg +: Seg] = s_seg[k];
    end
  end

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  assign ovf_d = c_seg[Last] ^ x_in[Last][WIDTH-1] ^ y_in[Last][WIDTH-1] ^ s_seg[Last][Seg-1];

  // Pipeline registers advance together; bubbles move with valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        x_q[k]     <= '0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= v_in[k];
        carry_q[k] <= c_seg[k];
        x_q[k]     <= x_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid    = valid_q[Last];
  assign out          = x_q[Last];
  assign out_carry    = carry_q[Last];
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed vector table, streaming/stall and reset sequences,
// a 1-stage 8-bit instance, and a randomized run against an arithmetic reference.
module tb_pipelined_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_carry, out_valid, out_ready, out_carry, out_overflow;
  logic [15:0] in_a, in_b, out;

  logic        in_valid1, in_ready1, in_carry1, out_valid1, out_ready1, out_carry1, out_overflow1;
  logic [7:0]  in_a1, in_b1, out1;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   popped = 0;
  exp_t exp_q[$];
  vec_t vecs[8];

  pipelined_adder #(
    .WIDTH (16),
    .STAGES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_carry    (in_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .out_carry   (out_carry),
    .out_overflow(out_overflow)
  );

  pipelined_adder #(
    .WIDTH (8),
    .STAGES(1)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid1),
    .in_ready    (in_ready1),
    .in_a        (in_a1),
    .in_b        (in_b1),
    .in_carry    (in_carry1),
    .out_valid   (out_valid1),
    .out_ready   (out_ready1),
    .out         (out1),
    .out_carry   (out_carry1),
    .out_overflow(out_overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer sum, and signed overflow as "true result out of range".
  function automatic exp_t ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t r;
    int   u;
    int   s;
    u       = 32'(a) + 32'(b) + 32'(c);
    s       = 32'($signed(a)) + 32'($signed(b)) + 32'(c);
    r.sum   = u[15:0];
    r.carry = u[16];
    r.ovf   = (s > 32767) || (s < -32768);
    return r;
  endfunction

  // Called at a negedge after inputs are driven; scores this cycle, then advances one clock.
  task automatic step(output bit accepted);
    exp_t e;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 0);
      end else begin
        e = exp_q[0];
        check("sb_sum", 32'(out), 32'(e.sum));
        check("sb_carry", 32'(out_carry), 32'(e.carry));
        check("sb_ovf", 32'(out_overflow), 32'(e.ovf));
        if (out_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
    if (accepted) exp_q.push_back(ref_add(in_a, in_b, in_carry));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts clock edges from acceptance until out_valid is seen.
  task automatic wait_result(input int want_lat);
    int lat;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(want_lat));
  endtask

  initial begin
    bit acc;
    int idx;
    int cyc;
    int base;
    int n_acc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0; in_a  = '0; in_b  = '0; in_carry  = 1'b0; out_ready  = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_carry1 = 1'b0; out_ready1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out", 32'(out), 0);
    check("rst_out_carry", 32'(out_carry), 0);
    check("rst_out_ovf", 32'(out_overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, first beat offered right after reset release.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_carry = vecs[i].c;
      step(acc);
      check("vec_accepted", 32'(acc), 1);
      in_valid = 1'b0;
      wait_result(4);
      check("vec_sum", 32'(out), 32'(vecs[i].sum));
      check("vec_carry", 32'(out_carry), 32'(vecs[i].carry));
      check("vec_ovf", 32'(out_overflow), 32'(vecs[i].ovf));
      step(acc);
    end

    // 8-beat stream; output stalled while stream cycles 7..9 have a result waiting.
    idx  = 0;
    cyc  = 0;
    base = popped;
    while ((popped - base) < 8 && cyc < 60) begin
      in_valid  = (idx < 8);
      in_a      = 16'(idx * 'h1111);
      in_b      = 16'h0F0F;
      in_carry  = 1'(idx & 1);
      out_ready = !(cyc >= 7 && cyc <= 9);
      #1;
      if (cyc >= 7 && cyc <= 9) begin
        check("stream_in_ready_low", 32'(in_ready), 0);
        check("stream_out_valid_held", 32'(out_valid), 1);
      end else if (in_valid) begin
        check("stream_in_ready_high", 32'(in_ready), 1);
      end
      step(acc);
      if (acc) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_results", 32'(popped - base), 8);
    check("stream_accepted", 32'(idx), 8);

    // Reset mid-flight discards three in-flight beats.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'(16'h3000 + i); in_b = 16'h0123; in_carry = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out", 32'(out), 0);
    check("midrst_carry", 32'(out_carry), 0);
    check("midrst_ovf", 32'(out_overflow), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("midrst_no_ghost", 32'(out_valid), 0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_carry = 1'b0;
    step(acc);
    in_valid = 1'b0;
    wait_result(4);
    check("postrst_sum", 32'(out), 32'h0002);
    check("postrst_carry", 32'(out_carry), 0);
    step(acc);

    // Single-stage 8-bit instance: latency 1.
    in_valid1 = 1'b1; in_a1 = 8'hFF; in_b1 = 8'hFF; in_carry1 = 1'b1;
    #1;
    check("s1_in_ready", 32'(in_ready1), 1);
    @(posedge clk);
    @(negedge clk);
    in_a1 = 8'h7F; in_b1 = 8'h00; in_carry1 = 1'b1;
    #1;
    check("s1_valid", 32'(out_valid1), 1);
    check("s1_sum", 32'(out1), 32'hFF);
    check("s1_carry", 32'(out_carry1), 1);
    check("s1_ovf", 32'(out_overflow1), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    #1;
    check("s1b_sum", 32'(out1), 32'h80);
    check("s1b_carry", 32'(out_carry1), 0);
    check("s1b_ovf", 32'(out_overflow1), 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("s1_idle", 32'(out_valid1), 0);
    @(negedge clk);

    // Randomized traffic with random backpressure.
    n_acc = 0;
    cyc   = 0;
    while ((n_acc < 10000 || exp_q.size() > 0) && cyc < 40000) begin
      in_valid  = (n_acc < 10000) && ($urandom_range(0, 3) != 0);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_carry  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) n_acc++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_accepted", 32'(n_acc), 10000);
    check("rand_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
